mem_read_responder: RTL and testbench
=====================================

Name: mem_read_responder

Overview:
- Memory-side responder for the CPU read channel. Serves instruction-fetch and data-read requests issued by the CPU initiator.
- Accepts one request at a time over a valid/ready handshake and returns a word after a fixed, programmable latency.
- Checks each request against a permission window and flags violations with an error code.
- Lives inside the memory top and is instantiated once per read channel (instruction, data).

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width; must be 32
- DEPTH, 1024, number of words in the backing array; power of two
- RD_LAT, 2, cycles from request accept to rsp_valid; legal range 1..15

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  read request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  byte address of the requested word
- rsp_valid  out  1  response valid
- rsp_ready  in  1  initiator accepts the response
- rsp_data  out  DATA_W  read data
- rsp_err  out  2  0=OK, 1=misaligned, 2=out of range, 3=permission denied
- perm_lo  in  ADDR_W  lowest readable byte address, inclusive
- perm_hi  in  ADDR_W  highest readable byte address, inclusive
- perm_rd_en  in  1  global read enable for this channel
- init_we  in  1  backdoor preload write enable
- init_addr  in  ADDR_W  backdoor write byte address (word aligned)
- init_wdata  in  DATA_W  backdoor write data

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=0 while rst=1, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0. Array contents are not reset.
- Handshake:
  - A request is accepted in a cycle where req_valid && req_ready.
  - A response completes in a cycle where rsp_valid && rsp_ready.
  - rsp_data and rsp_err are held stable while rsp_valid=1 && rsp_ready=0.
- FSM states:
  - IDLE: req_ready=1. On accept, latch address, error code and array word, then go to WAIT if RD_LAT>1, else to RESP.
  - WAIT: req_ready=0. Counter loads RD_LAT-2 on entry and decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: accept at cycle N gives rsp_valid=1 at cycle N+RD_LAT. Maximum throughput is one request per RD_LAT+1 cycles. There is no back-to-back accept in the same cycle as response completion.
- Error check, evaluated at accept, priority misaligned > out of range > perm:
  - misaligned: req_addr[1:0]!=0
  - out of range: req_addr >= DEPTH*4
  - perm denied: perm_rd_en=0, or req_addr<perm_lo, or req_addr>perm_hi
  - On any error, rsp_data=0 and a response is still returned with the same latency.
- Array index = req_addr[$clog2(DEPTH)+1:2].
- Read data is captured at accept. An init_we to the same word after accept does not alter the pending response.
- init_we:
  - Writes in any state, one cycle.
  - Misaligned or out-of-range init writes are ignored.
  - An init write in the same cycle as an accept to the same word: the response returns the OLD data (read-before-write).
- perm_* inputs are sampled only at accept; changes mid-transaction have no effect.
- rst mid-transaction drops the pending response immediately. No response is issued for that request.

Optional Feature:
- MEM_RD_PARITY_EN defined:
  - Array stores one even-parity bit per word, computed on init write.
  - Adds ports rsp_perr (out 1) and inj_perr (in 1). inj_perr=1 during init_we stores the inverted parity bit.
  - At accept, parity is recomputed over the stored word. On mismatch, rsp_perr=1 with data returned unchanged.
  - rsp_perr resets to 0 and is held like rsp_data.
- MEM_RD_PARITY_EN undefined: no parity storage and no extra ports.

Decomposition:
- Shared package mem_rd_pkg holds:
  - typedef rd_err_e: ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_PERM
  - typedef rd_state_e: IDLE, WAIT, RESP
  - constants RD_LAT_MAX=15 and WORD_BYTES=4
- One natural sub-module, mem_rd_perm_chk: combinational error-code generator from address, DEPTH and perm inputs. It is reusable by the write responder.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF; perm window 0x0..0xFFF, RD_LAT=2; read 0x10 at cycle N -> rsp_valid at N+2, rsp_data=0xDEADBEEF, rsp_err=0.
- Read 0x12 -> rsp_err=1, rsp_data=0. Read 0x1000 with DEPTH=1024 -> rsp_err=2. Read 0x800 with perm_hi=0x7FC -> rsp_err=3. Each response has the same latency.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_err stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Accept read of 0x20 (old 0x11111111) with init_we to 0x20 = 0x22222222 in the same cycle -> rsp_data=0x11111111; a following read returns 0x22222222.
- Assert rst during WAIT -> rsp_valid never asserts; after release req_ready=1; a new read completes normally.
- MEM_RD_PARITY_EN: preload 0x30 with inj_perr=1, then read -> rsp_perr=1, rsp_err=0, data intact. Without the macro, the build has no parity ports.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the memory read/write responders.
package mem_rd_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_PERM     = 2'd3
  } rd_err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_e;

  localparam int RD_LAT_MAX = 15;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_rd_perm_chk.sv
// Combinational access checker: alignment, array range and permission window,
// reported with priority misaligned > out of range > permission denied.
module mem_rd_perm_chk
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] perm_lo,
  input  logic [ADDR_W-1:0] perm_hi,
  input  logic              perm_rd_en,
  output rd_err_e           err
);

  // One extra bit so DEPTH*4 still fits when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * WORD_BYTES);

  always_comb begin
    err = ERR_OK;
    if (addr[1:0] != 2'b00) begin
      err = ERR_MISALIGN;
    end else if ({1'b0, addr} >= LIMIT) begin
      err = ERR_RANGE;
    end else if (!perm_rd_en || (addr < perm_lo) || (addr > perm_hi)) begin
      err = ERR_PERM;
    end
  end

endmodule

// File: rtl/mem_read_responder.sv
// Read-channel memory responder: one request at a time, fixed RD_LAT latency.
// Optional per-word even parity when MEM_RD_PARITY_EN is defined.
module mem_read_responder
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  input  logic [ADDR_W-1:0] perm_lo,
  input  logic [ADDR_W-1:0] perm_hi,
  input  logic              perm_rd_en,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata
`ifdef MEM_RD_PARITY_EN
  ,
  output logic              rsp_perr,
  input  logic              inj_perr
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef MEM_RD_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAT_LOAD = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  rd_state_e         state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic              data_ok_reg;
  rd_err_e           err_reg;
  rd_err_e           req_err;
  rd_err_e           init_err;
  logic              accept;
  logic              init_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word_reg;
  logic [MEM_W-1:0]  mem [DEPTH];

  mem_rd_perm_chk #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_req_chk (
    .addr       (req_addr),
    .perm_lo    (perm_lo),
    .perm_hi    (perm_hi),
    .perm_rd_en (perm_rd_en),
    .err        (req_err)
  );

  // Backdoor writes only need alignment and range, so the window is opened fully.
  mem_rd_perm_chk #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_init_chk (
    .addr       (init_addr),
    .perm_lo    ('0),
    .perm_hi    ('1),
    .perm_rd_en (1'b1),
    .err        (init_err)
  );

  assign accept  = req_valid && req_ready_reg;
  assign init_ok = init_we && (init_err == ERR_OK);
  assign rd_idx  = req_addr[IDX_W+1:2];
  assign wr_idx  = init_addr[IDX_W+1:2];

`ifdef MEM_RD_PARITY_EN
  assign wr_word  = {(^init_wdata) ^ inj_perr, init_wdata};
  assign rsp_perr = data_ok_reg & (^rd_word_reg);
`else
  assign wr_word  = init_wdata;
`endif

  // Read register loads only on accept, so a same-cycle or later write leaves the captured word intact.
  always_ff @(posedge clk) begin
    if (init_ok) begin
      mem[wr_idx] <= wr_word;
    end
    if (accept) begin
      rd_word_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      data_ok_reg   <= 1'b0;
      err_reg       <= ERR_OK;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_ready_reg <= 1'b0;
            err_reg       <= req_err;
            data_ok_reg   <= (req_err == ERR_OK);
            if (RD_LAT > 1) begin
              state_reg <= WAIT;
              cnt_reg   <= LAT_LOAD;
            end else begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
            end
          end else begin
            req_ready_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
          req_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = err_reg;
  assign rsp_data  = data_ok_reg ? rd_word_reg[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder; parity checks active with MEM_RD_PARITY_EN.
module tb_mem_read_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] perm_lo = '0;
  logic [ADDR_W-1:0] perm_hi = 32'hFFF;
  logic              perm_rd_en = 1'b1;
  logic              init_we = 1'b0;
  logic [ADDR_W-1:0] init_addr = '0;
  logic [DATA_W-1:0] init_wdata = '0;
`ifdef MEM_RD_PARITY_EN
  logic              rsp_perr;
  logic              inj_perr = 1'b0;
`endif

  mem_read_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .perm_lo    (perm_lo),
    .perm_hi    (perm_hi),
    .perm_rd_en (perm_rd_en),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata)
`ifdef MEM_RD_PARITY_EN
    ,
    .rsp_perr   (rsp_perr),
    .inj_perr   (inj_perr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  err;
    logic        perr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  bit          rsp_seen = 1'b0;
  logic [31:0] model_mem [DEPTH];
  bit          perr_model [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change 1ns after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_err(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'd1;
    if (a >= 32'(DEPTH * 4)) return 2'd2;
    if (!perm_rd_en || a < perm_lo || a > perm_hi) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input bit inj);
    if (a[1:0] == 2'b00 && a < 32'(DEPTH * 4)) begin
      model_mem[a[11:2]]  = d;
      perr_model[a[11:2]] = inj;
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input bit inj);
    init_we    = 1'b1;
    init_addr  = a;
    init_wdata = d;
`ifdef MEM_RD_PARITY_EN
    inj_perr   = inj;
`endif
    step();
    init_we = 1'b0;
`ifdef MEM_RD_PARITY_EN
    inj_perr = 1'b0;
`endif
    model_write(a, d, inj);
  endtask

  task automatic do_read(input logic [31:0] a, input bit co_wr, input logic [31:0] co_data);
    exp_t e;
    int   n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    e.addr = a;
    e.err  = exp_err(a);
    e.data = (e.err == 2'd0) ? model_mem[a[11:2]] : 32'h0;
    e.perr = (e.err == 2'd0) ? perr_model[a[11:2]] : 1'b0;
    e.acc  = cyc;
    sb.push_back(e);
    req_valid = 1'b1;
    req_addr  = a;
    if (co_wr) begin
      init_we    = 1'b1;
      init_addr  = a;
      init_wdata = co_data;
    end
    step();
    req_valid = 1'b0;
    init_we   = 1'b0;
    if (co_wr) model_write(a, co_data, 1'b0);
    chk("req_ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor samples 1ns before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rsp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
`ifdef MEM_RD_PARITY_EN
        chk("rsp_perr", 32'(rsp_perr), 32'(sb[0].perr));
`endif
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (!rsp_seen) begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(RD_LAT));
          rsp_seen = 1'b1;
        end
        if (rsp_ready === 1'b1) begin
          $display("rsp addr=%h data=%h err=%0d cycle=%0d", sb[0].addr, rsp_data, rsp_err, cyc);
          void'(sb.pop_front());
          rsp_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [31:0] a;

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef MEM_RD_PARITY_EN
    chk("rst_rsp_perr", 32'(rsp_perr), 32'd0);
`endif
    rst = 1'b0;
    step();
    step();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      write_word(32'(i) * 4, 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003), 1'b0);
    end

    // Basic read and each error class
    write_word(32'h10, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h10, 1'b0, 32'h0);
    wait_idle();
    do_read(32'h12, 1'b0, 32'h0);
    wait_idle();
    do_read(32'h1000, 1'b0, 32'h0);
    wait_idle();
    perm_hi = 32'h7FC;
    do_read(32'h800, 1'b0, 32'h0);
    wait_idle();
    do_read(32'h7FC, 1'b0, 32'h0);
    wait_idle();
    perm_lo = 32'h10;
    do_read(32'hC, 1'b0, 32'h0);
    wait_idle();
    do_read(32'h10, 1'b0, 32'h0);
    wait_idle();
    perm_lo = 32'h0;
    perm_hi = 32'hFFF;
    perm_rd_en = 1'b0;
    do_read(32'h10, 1'b0, 32'h0);
    wait_idle();
    perm_rd_en = 1'b1;
    do_read(32'hFFC, 1'b0, 32'h0);
    wait_idle();

    // Illegal backdoor writes must not alias onto word 0
    write_word(32'h0, 32'h1234_5678, 1'b0);
    write_word(32'h1000, 32'hBAD0_BAD0, 1'b0);
    write_word(32'h2, 32'hBAD1_BAD1, 1'b0);
    do_read(32'h0, 1'b0, 32'h0);
    wait_idle();

    // Backpressure hold
    rsp_ready = 1'b0;
    do_read(32'h10, 1'b0, 32'h0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("hold_valid_seen", 32'(rsp_valid), 32'd1);
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    chk("hold_valid_drop", 32'(rsp_valid), 32'd0);
    chk("hold_idle_ready", 32'(req_ready), 32'd1);
    wait_idle();

    // Same-cycle write returns old data
    write_word(32'h20, 32'h1111_1111, 1'b0);
    do_read(32'h20, 1'b1, 32'h2222_2222);
    wait_idle();
    do_read(32'h20, 1'b0, 32'h0);
    wait_idle();

    // Write and perm change after accept do not affect pending response
    do_read(32'h50, 1'b0, 32'h0);
    write_word(32'h50, 32'hCAFE_F00D, 1'b0);
    wait_idle();
    do_read(32'h50, 1'b0, 32'h0);
    perm_rd_en = 1'b0;
    wait_idle();
    perm_rd_en = 1'b1;

    // Reset during WAIT drops the response
    do_read(32'h10, 1'b0, 32'h0);
    rst = 1'b1;
    sb.delete();
    rsp_seen = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (4) step();
    rst = 1'b0;
    step();
    step();
    chk("postrst_req_ready", 32'(req_ready), 32'd1);
    do_read(32'h10, 1'b0, 32'h0);
    wait_idle();

`ifdef MEM_RD_PARITY_EN
    write_word(32'h30, 32'hA5A5_0F0F, 1'b1);
    do_read(32'h30, 1'b0, 32'h0);
    wait_idle();
    write_word(32'h34, 32'h0000_0007, 1'b0);
    do_read(32'h34, 1'b0, 32'h0);
    wait_idle();
`endif

    // Randomised mix
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 7);
      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = a + 32'h1000;
      perm_hi = (r == 2) ? 32'h400 : 32'hFFF;
      if ($urandom_range(0, 1) == 1) write_word(32'($urandom_range(0, DEPTH - 1)) * 4, $urandom, 1'b0);
      rsp_ready = ($urandom_range(0, 1) == 1);
      do_read(a, 1'b0, 32'h0);
      repeat ($urandom_range(0, 3)) step();
      rsp_ready = 1'b1;
      wait_idle();
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
